// File: rtl/ratio_counter_pkg.sv
// ratio_counter_pkg: shared encodings for the ratio counter.
// FSM states, status byte layout and adder slicing.
package ratio_counter_pkg;

  localparam int STATUS_WIDTH = 8;
  localparam int SLICE_W      = 12;

  localparam int ST_DONE_BIT = 7;
  localparam int ST_OVF_BIT  = 6;
  localparam int ST_ORUN_BIT = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPI,
    S_ARM,
    S_COUNT,
    S_DONE
  } state_t;

  function automatic int n_slices(input int w);
    return (w + SLICE_W - 1) / SLICE_W;
  endfunction

endpackage

// File: rtl/ratio_counter_sync.sv
// ratio_counter_sync: multi-flop synchroniser for one async bit.
// Chain clears to 0 while reset is held.
module ratio_counter_sync
  import ratio_counter_pkg::*;
#(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain;

  // shift the async bit through DEPTH flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[DEPTH-2:0], d};
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/ratio_counter.sv
// ratio_counter: MAJOR/MINOR clock ratio meter with SPI access.
// RATIO_COUNTER_CONTINUOUS_EN: free-running re-arm with result shadow.
module ratio_counter
  import ratio_counter_pkg::*;
#(
  parameter int   UPCOUNT_WIDTH   = 40,
  parameter int   DOWNCOUNT_WIDTH = 16,
  parameter logic CPOL            = 1'b1,
  parameter int   SYNC_DEPTH      = 5
) (
  input  logic MAJOR_CLOCK,
  input  logic RESET_N,
  input  logic SCK,
  input  logic SS,
  input  logic SDI,
  output logic SDO,
  output logic SDO_OE,
  input  logic MINOR_CLOCK,
  output logic FPGA_INT
);

  localparam int UW = UPCOUNT_WIDTH;
  localparam int DW = DOWNCOUNT_WIDTH;
  localparam int W  = STATUS_WIDTH + DW + UW;
  localparam int UN = n_slices(UW);
  localparam int DN = n_slices(DW);

  logic [1:0] rst_q;
  logic       rst_n;

  // assert async, release two clocks later
  always_ff @(posedge MAJOR_CLOCK or negedge RESET_N) begin
    if (!RESET_N) rst_q <= '0;
    else          rst_q <= {rst_q[0], 1'b1};
  end

  assign rst_n = rst_q[1];

  logic ss_q, sck_q, sdi_q, mn_q;
  logic ss_d, sck_d, mn_d;

  ratio_counter_sync #(.DEPTH(SYNC_DEPTH)) u_sync_ss (
    .clk(MAJOR_CLOCK), .rst_n(rst_n), .d(SS), .q(ss_q)
  );
  ratio_counter_sync #(.DEPTH(SYNC_DEPTH)) u_sync_sck (
    .clk(MAJOR_CLOCK), .rst_n(rst_n), .d(SCK ^ CPOL), .q(sck_q)
  );
  ratio_counter_sync #(.DEPTH(SYNC_DEPTH)) u_sync_sdi (
    .clk(MAJOR_CLOCK), .rst_n(rst_n), .d(SDI), .q(sdi_q)
  );
  ratio_counter_sync #(.DEPTH(SYNC_DEPTH)) u_sync_mn (
    .clk(MAJOR_CLOCK), .rst_n(rst_n), .d(MINOR_CLOCK), .q(mn_q)
  );

  // edge-detect stage behind the synchronisers
  always_ff @(posedge MAJOR_CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      ss_d  <= 1'b0;
      sck_d <= 1'b0;
      mn_d  <= 1'b0;
    end else begin
      ss_d  <= ss_q;
      sck_d <= sck_q;
      mn_d  <= mn_q;
    end
  end

  logic cs_rise, cs_fall, sck_smp, sck_lat, mn_rise;

  assign cs_rise = ss_d & ~ss_q;
  assign cs_fall = ~ss_d & ss_q;
  assign sck_smp = ~sck_d & sck_q;
  assign sck_lat = sck_d & ~sck_q;
  assign mn_rise = ~mn_d & mn_q;

  state_t state, state_nx;
  logic [STATUS_WIDTH-1:0] st_sh, live_st;
  logic [DW-1:0] dc;
  logic [UW-1:0] uc;
  logic [W-1:0]  word;
  logic sdo_q, int_q, done_q, ovf_q;

  assign word = {st_sh, dc, uc};

  logic [UN-1:0] up_ones, up_cin;
  logic [UW-1:0] up_nxt;
  logic [DN-1:0] dn_zero, dn_bin;
  logic [DW-1:0] dn_nxt;
  logic up_sat, dc_zero, dc_one;

  for (genvar s = 0; s < UN; s++) begin : g_up
    localparam int LO = s * SLICE_W;
    localparam int HI = (LO + SLICE_W > UW) ? UW - 1 : LO + SLICE_W - 1;
    localparam int SW = HI - LO + 1;
    assign up_ones[s]    = &uc[HI:LO];
    assign up_nxt[HI:LO] = uc[HI:LO] + SW'(up_cin[s]);
  end

  for (genvar s = 0; s < DN; s++) begin : g_dn
    localparam int LO = s * SLICE_W;
    localparam int HI = (LO + SLICE_W > DW) ? DW - 1 : LO + SLICE_W - 1;
    localparam int SW = HI - LO + 1;
    assign dn_zero[s]    = ~|dc[HI:LO];
    assign dn_nxt[HI:LO] = dc[HI:LO] - SW'(dn_bin[s]);
  end

  // slice carry/borrow look-ahead from per-slice flags
  always_comb begin
    up_cin    = '0;
    dn_bin    = '0;
    up_cin[0] = 1'b1;
    dn_bin[0] = 1'b1;
    for (int s = 1; s < UN; s++) up_cin[s] = up_cin[s-1] & up_ones[s-1];
    for (int s = 1; s < DN; s++) dn_bin[s] = dn_bin[s-1] & dn_zero[s-1];
  end

  assign up_sat  = &up_ones;
  assign dc_zero = &dn_zero;
  assign dc_one  = (dc == DW'(1));

`ifdef RATIO_COUNTER_CONTINUOUS_EN
  logic [DW-1:0] dc_rel, sh_dc;
  logic [UW-1:0] sh_uc;
  logic sh_v, orun_q;
`endif

  // live status byte
  always_comb begin
    live_st = '0;
    live_st[ST_DONE_BIT] = done_q;
    live_st[ST_OVF_BIT]  = ovf_q;
`ifdef RATIO_COUNTER_CONTINUOUS_EN
    live_st[ST_ORUN_BIT] = orun_q;
`endif
  end

  // state register
  always_ff @(posedge MAJOR_CLOCK or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next state; CS assertion wins from any state
  always_comb begin
    state_nx = state;
    if (cs_rise) begin
      state_nx = S_SPI;
    end else begin
      unique case (state)
        S_SPI:   if (cs_fall) state_nx = dc_zero ? S_IDLE : S_ARM;
        S_ARM:   if (mn_rise) state_nx = S_COUNT;
        S_COUNT: if (mn_rise && dc_one) state_nx = S_DONE;
`ifdef RATIO_COUNTER_CONTINUOUS_EN
        S_DONE:  state_nx = S_ARM;
`endif
        default: ;
      endcase
    end
  end

  // shift word, counters, status and outputs
  always_ff @(posedge MAJOR_CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      st_sh  <= '0;
      dc     <= '0;
      uc     <= '0;
      sdo_q  <= 1'b0;
      int_q  <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
`ifdef RATIO_COUNTER_CONTINUOUS_EN
      dc_rel <= '0;
      sh_dc  <= '0;
      sh_uc  <= '0;
      sh_v   <= 1'b0;
      orun_q <= 1'b0;
`endif
    end else begin
      int_q <= (state == S_DONE) && ss_q;
      if (cs_rise) begin
        st_sh <= live_st;
        sdo_q <= live_st[STATUS_WIDTH-1];
`ifdef RATIO_COUNTER_CONTINUOUS_EN
        dc     <= sh_dc;
        uc     <= sh_uc;
        sh_v   <= 1'b0;
        orun_q <= 1'b0;
`endif
      end else begin
        if (state != S_SPI) begin
          st_sh <= live_st;
          sdo_q <= st_sh[STATUS_WIDTH-1];
        end
        unique case (state)
          S_SPI: begin
            if (sck_smp) {st_sh, dc, uc} <= {word[W-2:0], sdi_q};
            if (sck_lat) sdo_q <= word[W-1];
            if (cs_fall && !dc_zero) begin
              done_q <= 1'b0;
              ovf_q  <= 1'b0;
`ifdef RATIO_COUNTER_CONTINUOUS_EN
              dc_rel <= dc;
`endif
            end
          end
          S_COUNT: begin
            if (up_sat) ovf_q <= 1'b1;
            else        uc    <= up_nxt;
            if (mn_rise) begin
              dc <= dn_nxt;
              if (dc_one) done_q <= 1'b1;
            end
          end
`ifdef RATIO_COUNTER_CONTINUOUS_EN
          S_DONE: begin
            sh_dc  <= dc_rel;
            sh_uc  <= uc;
            sh_v   <= 1'b1;
            orun_q <= orun_q | sh_v;
            dc     <= dc_rel;
            uc     <= '0;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign SDO      = sdo_q;
  assign SDO_OE   = ~SS;
  assign FPGA_INT = int_q;

endmodule
